// File: rtl/w_fetch_seq.sv
// Weight-memory read sequencer: walks addresses 0..numWeight-1 and streams
// the weights out through a 2-entry skid FIFO with credit-based read issue.
module w_fetch_seq #(
    parameter int numWeight    = 30,
    parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_ren,
    output logic [addressWidth-1:0] mem_radd,
    input  logic [dataWidth-1:0]    mem_rdata,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [dataWidth-1:0]    w_data,
    output logic [addressWidth-1:0] w_index,
    output logic                    w_last
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FLUSH_DONE
    } state_t;

    localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

    state_t                  state;
    logic [addressWidth-1:0] cnt;
    logic [addressWidth-1:0] radd_q;
    logic                    inflight;

    logic [dataWidth-1:0]    fd [2];
    logic [addressWidth-1:0] fi [2];
    logic                    rp;
    logic                    wp;
    logic [1:0]              count;

    logic                    pop;
    logic                    push;
    logic [2:0]              occ;

    assign pop     = w_valid & w_ready;
    assign push    = inflight;
    assign w_valid = (count != 2'd0);
    assign w_data  = fd[rp];
    assign w_index = fi[rp];
    assign w_last  = w_valid && (fi[rp] == LAST);

    // Slots already committed: stored beats plus the read still in flight.
    assign occ      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign mem_ren  = (state == FETCH) && (occ < 3'd2);
    assign mem_radd = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            radd_q   <= '0;
            inflight <= 1'b0;
            rp       <= 1'b0;
            wp       <= 1'b0;
            count    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fd[i] <= '0;
                fi[i] <= '0;
            end
        end else begin
            inflight <= mem_ren;
            if (mem_ren) radd_q <= cnt;
            if (push) begin
                fd[wp] <= mem_rdata;
                fi[wp] <= radd_q;
                wp     <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ren) begin
                        if (cnt == LAST) state <= DRAIN;
                        else cnt <= cnt + addressWidth'(1);
                    end
                end
                DRAIN: begin
                    if (pop && w_last) begin
                        state <= FLUSH_DONE;
                        done  <= 1'b1;
                    end
                end
                FLUSH_DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
